nios2_dbg_sysclk_cmdq: RTL and testbench
========================================

Name: nios2_dbg_sysclk_cmdq

Overview:
Parametrised sysclk-side front end for the Nios II JTAG debug slave. It synchronises the TCK-domain update strobes (vs_uir, vs_udr) into clk. It captures the instruction register and the shift-register snapshot, then queues each completed DR update as a command. Commands are presented to the OCI/break/trace logic through a valid/ready handshake, with one-hot take-action and take-no-action decode. It replaces fixed-width, single-register, unbuffered capture with configurable widths, sync depth and a command queue with overflow reporting.

Parameters:
SR_W, 38, width of the JTAG data shift-register snapshot (sr, cmd_data)
IR_W, 2, width of the virtual-JTAG instruction register; decode width is 2**IR_W
SYNC_STAGES, 2, flip-flop stages on vs_uir and vs_udr; legal range 2..4
DEPTH, 4, command queue entries; power of two, minimum 2
ACT_BIT, 37, index in sr selecting action (1) versus no-action (0)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sr  in  SR_W  TCK-domain shift-register snapshot; held stable at least SYNC_STAGES+3 clk cycles after vs_udr rises
ir_in  in  IR_W  TCK-domain instruction register; held stable at least SYNC_STAGES+3 clk cycles after vs_uir rises
vs_uir  in  1  TCK-domain update-IR level, asynchronous to clk
vs_udr  in  1  TCK-domain update-DR level, asynchronous to clk
cmd_valid  out  1  queue head valid
cmd_ready  in  1  consumer accepts head when cmd_valid && cmd_ready
cmd_ir  out  IR_W  IR value at the head entry
cmd_data  out  SR_W  sr snapshot at the head entry (jdo equivalent)
cmd_act  out  2**IR_W  one-hot take_action decode
cmd_noact  out  2**IR_W  one-hot take_no_action decode
level  out  $clog2(DEPTH)+1  number of queued entries
overflow  out  1  sticky: an update was dropped because the queue was full
overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release by system reset logic) clears all of: synchroniser flops, edge-detect flops, ir_q, queue pointers, level, overflow.
- Reset values: cmd_valid=0, cmd_ir=0, cmd_data=0, cmd_act=0, cmd_noact=0, level=0, overflow=0.
- Reset mid-operation discards all queued entries and any update in flight.
- Synchronisers: SYNC_STAGES flops, then one delay flop.
  - uir_pulse = synced & ~delayed.
  - udr_pulse is formed the same way.
  - Each pulse is one clk cycle per rising edge only; a held level produces no repeat.
- On uir_pulse: ir_q <= ir_in.
- On udr_pulse: push {ir_q, sr}.
  - If uir_pulse and udr_pulse coincide, the pushed entry uses the old ir_q. ir_q still updates in that cycle.
- Queue is a circular buffer with registered outputs.
  - Empty, no pop: cmd_valid=0, and cmd_ir/cmd_data hold their last values.
  - Latency with queue empty: cmd_valid rises exactly SYNC_STAGES+2 clk edges after the first edge that samples vs_udr=1.
  - Pop when cmd_valid && cmd_ready. The next entry, if any, is presented on the following cycle with no bubble.
- Full (level==DEPTH):
  - Push without a simultaneous pop: entry dropped, overflow<=1, contents unchanged.
  - Push with a simultaneous pop: accepted, level unchanged.
- Empty with simultaneous push and pop: impossible, since pop requires cmd_valid.
- overflow:
  - overflow_clr clears it.
  - If overflow_clr and a drop occur in the same cycle, the drop wins and overflow stays 1.
- level updates as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
- Decode (combinational from the registered head):
  - cmd_act = cmd_valid && cmd_data[ACT_BIT] ? (1<<cmd_ir) : 0.
  - cmd_noact = cmd_valid && !cmd_data[ACT_BIT] ? (1<<cmd_ir) : 0.
  - At most one bit across both vectors is set.
- Elaboration errors: ACT_BIT >= SR_W, DEPTH not a power of two, or SYNC_STAGES outside 2..4.

Decomposition:
- Shared package nios2_dbg_pkg holds:
  - the IR encodings (IR_OCIMEM=0, IR_TRACECTRL=1, IR_BREAK=2, IR_TRACEMEM=3);
  - the cmd entry struct {ir, data};
  - the default widths.
- One sub-module, nios2_dbg_sync_edge: SYNC_STAGES synchroniser plus rising-edge pulse, instantiated twice.

Test Plan:
- Single update, queue empty: ir_in=2, vs_uir 0->1; later sr=38'h20_0000_00A5, vs_udr 0->1.
  -> cmd_valid at edge SYNC_STAGES+2 after vs_udr sampled; cmd_ir=2; cmd_act=4'b0100; cmd_noact=0; level=1.
- No-action decode: sr[37]=0, ir=0, cmd_ready held 1.
  -> cmd_noact=4'b0001 for exactly one cycle; level back to 0.
- Fill then overflow: 5 udr edges with cmd_ready=0, DEPTH=4.
  -> level=4, overflow=1, head still holds the 1st entry.
  -> drain 4 and check FIFO order; 5th entry absent.
- Full plus simultaneous pop and push: level=4, cmd_ready=1 in the udr_pulse cycle.
  -> overflow stays 0, level stays 4, new entry last out.
- Held level: vs_udr held high for 50 cycles.
  -> exactly one push; overflow_clr coinciding with a drop leaves overflow=1.
- Reset mid-stream: assert reset_n=0 with level=3.
  -> all outputs zero immediately (async); after release no stale entry appears.

Source files
------------

// File: rtl/nios2_dbg_pkg.sv
// Shared encodings, default widths and entry type for the Nios II debug
// sysclk-side command front end.
package nios2_dbg_pkg;

    localparam int SR_W_DEF        = 38;
    localparam int IR_W_DEF        = 2;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEPTH_DEF       = 4;
    localparam int ACT_BIT_DEF     = 37;

    // Virtual-JTAG instruction register encodings
    typedef enum logic [IR_W_DEF-1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACECTRL = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACEMEM  = 2'd3
    } ir_e;

    // One queued command: instruction register plus shift-register snapshot
    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] data;
    } cmd_entry_t;

    // True when n is a positive power of two
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// Multi-flop synchroniser for a TCK-domain level, followed by a delay flop
// that turns each rising edge into a single clk-cycle pulse.
module nios2_dbg_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic pulse_o
);

    if ((STAGES < 2) || (STAGES > 4)) begin : g_chk_stages
        $error("nios2_dbg_sync_edge: STAGES must be in 2..4");
    end

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Shift the asynchronous level through the synchroniser and delay flop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    // A held level yields one pulse only: high while synced and not yet delayed
    assign pulse_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/nios2_dbg_sysclk_cmdq.sv
// Sysclk-side front end of the Nios II JTAG debug slave: synchronises the
// update-IR/update-DR strobes, captures IR and the DR snapshot, and queues
// each DR update as a command with registered head and one-hot decode.
module nios2_dbg_sysclk_cmdq
    import nios2_dbg_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SR_W-1:0]          sr,
    input  logic [IR_W-1:0]          ir_in,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [SR_W-1:0]          cmd_data,
    output logic [(2**IR_W)-1:0]     cmd_act,
    output logic [(2**IR_W)-1:0]     cmd_noact,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int NDEC  = 2**IR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [NDEC-1:0] ONE_HOT_LSB = {{(NDEC-1){1'b0}}, 1'b1};

    if (ACT_BIT >= SR_W) begin : g_chk_act
        $error("nios2_dbg_sysclk_cmdq: ACT_BIT must index inside sr");
    end
    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_chk_depth
        $error("nios2_dbg_sysclk_cmdq: DEPTH must be a power of two >= 2");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_chk_sync
        $error("nios2_dbg_sysclk_cmdq: SYNC_STAGES must be in 2..4");
    end

    logic             uir_pulse_s, udr_pulse_s;
    logic             uir_pulse_q, udr_pulse_q;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [IR_W-1:0]  mem_ir_q   [DEPTH];
    logic [SR_W-1:0]  mem_data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [IR_W-1:0]  cmd_ir_q, cmd_ir_d;
    logic [SR_W-1:0]  cmd_data_q, cmd_data_d;
    logic             pop_s, full_s, push_ok_s, drop_s;

    nios2_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .async_i (vs_uir),
        .pulse_o (uir_pulse_s)
    );

    nios2_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .async_i (vs_udr),
        .pulse_o (udr_pulse_s)
    );

    // Handshake, capacity and drop qualification for this cycle
    always_comb begin
        pop_s     = cmd_valid_q & cmd_ready;
        full_s    = (level_q == LVL_W'(DEPTH));
        push_ok_s = udr_pulse_q & (~full_s | pop_s);
        drop_s    = udr_pulse_q & full_s & ~pop_s;
        rd_next_s = rd_ptr_q + PTR_W'(1);
    end

    // Next-state for IR capture, pointers, level, overflow and the head register
    always_comb begin
        ir_d        = ir_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        cmd_valid_d = cmd_valid_q;
        cmd_ir_d    = cmd_ir_q;
        cmd_data_d  = cmd_data_q;

        // The pushed entry uses the pre-update ir_q when both strobes coincide
        if (uir_pulse_q) begin
            ir_d = ir_in;
        end else begin
            ir_d = ir_q;
        end

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_next_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A drop outranks a same-cycle clear so no loss goes unreported
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        // Head register: refill straight from the next entry on pop (no bubble)
        if (pop_s) begin
            if (level_q >= LVL_W'(2)) begin
                cmd_valid_d = 1'b1;
                cmd_ir_d    = mem_ir_q[rd_next_s];
                cmd_data_d  = mem_data_q[rd_next_s];
            end else begin
                cmd_valid_d = 1'b0;
            end
        end else if (!cmd_valid_q && (level_q != LVL_W'(0))) begin
            cmd_valid_d = 1'b1;
            cmd_ir_d    = mem_ir_q[rd_ptr_q];
            cmd_data_d  = mem_data_q[rd_ptr_q];
        end else begin
            cmd_valid_d = cmd_valid_q;
        end
    end

    // Control and head state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_pulse_q <= 1'b0;
            udr_pulse_q <= 1'b0;
            ir_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_ir_q    <= '0;
            cmd_data_q  <= '0;
        end else begin
            uir_pulse_q <= uir_pulse_s;
            udr_pulse_q <= udr_pulse_s;
            ir_q        <= ir_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_ir_q    <= cmd_ir_d;
            cmd_data_q  <= cmd_data_d;
        end
    end

    // Queue storage, written at the tail on every accepted push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_ir_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_ir_q[wr_ptr_q]   <= ir_q;
            mem_data_q[wr_ptr_q] <= sr;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_ir    = cmd_ir_q;
    assign cmd_data  = cmd_data_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign cmd_act   = (cmd_valid_q &&  cmd_data_q[ACT_BIT]) ? (ONE_HOT_LSB << cmd_ir_q) : '0;
    assign cmd_noact = (cmd_valid_q && !cmd_data_q[ACT_BIT]) ? (ONE_HOT_LSB << cmd_ir_q) : '0;

endmodule

// File: tb/tb_nios2_dbg_sysclk_cmdq.sv
// Self-checking bench for nios2_dbg_sysclk_cmdq: directed scenarios plus a
// randomized phase, all compared against a transaction-level queue model.
module tb_nios2_dbg_sysclk_cmdq;
    import nios2_dbg_pkg::*;

    localparam int SR_W        = 38;
    localparam int IR_W        = 2;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 4;
    localparam int ACT_BIT     = 37;
    localparam int NDEC        = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [SR_W-1:0] sr = '0;
    logic [IR_W-1:0] ir_in = '0;
    logic            vs_uir = 1'b0, vs_udr = 1'b0;
    logic            cmd_valid, cmd_ready = 1'b0;
    logic [IR_W-1:0] cmd_ir;
    logic [SR_W-1:0] cmd_data;
    logic [NDEC-1:0] cmd_act, cmd_noact;
    logic [2:0]      level;
    logic            overflow, overflow_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    cmd_entry_t      model_q[$];
    logic [IR_W-1:0] model_ir = '0;
    bit              model_ovf = 1'b0;

    nios2_dbg_sysclk_cmdq #(
        .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(SYNC_STAGES), .DEPTH(DEPTH), .ACT_BIT(ACT_BIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .cmd_act(cmd_act), .cmd_noact(cmd_noact), .level(level), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [IR_W-1:0] ir_v, input logic [SR_W-1:0] d_v);
        cmd_entry_t e;
        e.ir   = ir_v;
        e.data = d_v;
        if (model_q.size() == DEPTH) model_ovf = 1'b1;
        else model_q.push_back(e);
    endtask

    task automatic model_pop();
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic check_state(input string tag);
        cmd_entry_t      h;
        logic [NDEC-1:0] oh;
        check_eq({tag, " level"}, 64'(level), 64'(model_q.size()));
        check_eq({tag, " valid"}, 64'(cmd_valid), 64'(model_q.size() > 0));
        check_eq({tag, " overflow"}, 64'(overflow), 64'(model_ovf));
        if (model_q.size() > 0) begin
            h  = model_q[0];
            oh = 4'b0001 << h.ir;
            check_eq({tag, " ir"}, 64'(cmd_ir), 64'(h.ir));
            check_eq({tag, " data"}, 64'(cmd_data), 64'(h.data));
            check_eq({tag, " act"}, 64'(cmd_act), h.data[ACT_BIT] ? 64'(oh) : 64'd0);
            check_eq({tag, " noact"}, 64'(cmd_noact), h.data[ACT_BIT] ? 64'd0 : 64'(oh));
        end else begin
            check_eq({tag, " act"}, 64'(cmd_act), 64'd0);
            check_eq({tag, " noact"}, 64'(cmd_noact), 64'd0);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        vs_uir = 1'b0; vs_udr = 1'b0; cmd_ready = 1'b0; overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        model_q.delete();
        model_ir  = '0;
        model_ovf = 1'b0;
    endtask

    // TCK-side update: optionally IR and/or DR, raised together, held, then released
    task automatic tck_update(input bit do_ir, input bit do_dr,
                              input logic [IR_W-1:0] ir_v, input logic [SR_W-1:0] sr_v);
        @(negedge clk);
        if (do_ir) ir_in = ir_v;
        if (do_dr) sr = sr_v;
        vs_uir = do_ir;
        vs_udr = do_dr;
        repeat (SYNC_STAGES + 4) @(negedge clk);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
        if (do_dr) model_push(model_ir, sr_v);
        if (do_ir) model_ir = ir_v;
    endtask

    task automatic pop_one();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        model_pop();
    endtask

    task automatic clr_ovf();
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        model_ovf = 1'b0;
    endtask

    // DR update whose push cycle coincides with a one-cycle pulse on ready or clr
    task automatic udr_with_strobe(input logic [SR_W-1:0] sr_v, input bit use_ready);
        @(negedge clk);
        sr = sr_v;
        vs_udr = 1'b1;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        if (use_ready) cmd_ready = 1'b1;
        else overflow_clr = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
        if (use_ready) model_pop();
        model_push(model_ir, sr_v);
    endtask

    function automatic logic [SR_W-1:0] rnd_sr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[SR_W-1:0];
    endfunction

    initial begin
        int lat;
        int cnt;
        logic [SR_W-1:0] tmp;

        do_reset();
        check_state("reset");
        check_eq("reset cmd_ir", 64'(cmd_ir), 64'd0);
        check_eq("reset cmd_data", 64'(cmd_data), 64'd0);

        // Single update with latency measurement
        tck_update(1'b1, 1'b0, 2'd2, '0);
        @(negedge clk);
        sr = 38'h20_0000_00A5;
        vs_udr = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (cmd_valid && (lat == 0)) lat = i;
        end
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
        model_push(model_ir, 38'h20_0000_00A5);
        check_eq("latency", 64'(lat), 64'(SYNC_STAGES + 2));
        check_eq("single ir", 64'(cmd_ir), 64'd2);
        check_eq("single act", 64'(cmd_act), 64'b0100);
        check_state("single");
        pop_one();
        check_state("single popped");

        // No-action decode with ready held high
        tck_update(1'b1, 1'b0, 2'd0, '0);
        cmd_ready = 1'b1;
        @(negedge clk);
        sr = 38'h0_0000_1234;
        vs_udr = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_noact === 4'b0001) cnt++;
            if (i == SYNC_STAGES + 4) vs_udr = 1'b0;
        end
        cmd_ready = 1'b0;
        check_eq("noact cycles", 64'(cnt), 64'd1);
        check_state("noact done");

        // Fill then overflow, then drain in order
        for (int i = 0; i < 5; i++) tck_update(1'b0, 1'b1, '0, rnd_sr());
        check_state("fill5");
        for (int i = 0; i < 4; i++) begin
            pop_one();
            check_state("drain5");
        end
        clr_ovf();
        check_state("ovf cleared");

        // Full queue with push and pop in the same cycle
        for (int i = 0; i < 4; i++) tck_update(1'b1, 1'b1, 2'(i), rnd_sr());
        check_state("fill4");
        udr_with_strobe(rnd_sr(), 1'b1);
        check_state("full push+pop");
        for (int i = 0; i < 4; i++) begin
            pop_one();
            check_state("drain4");
        end

        // Held level: only the rising edge pushes
        @(negedge clk);
        tmp = rnd_sr();
        sr = tmp;
        vs_udr = 1'b1;
        repeat (50) @(negedge clk);
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
        model_push(model_ir, tmp);
        check_state("held");
        pop_one();

        // Coincident IR and DR updates: entry carries the old IR
        tck_update(1'b1, 1'b1, 2'd1, rnd_sr());
        tck_update(1'b0, 1'b1, '0, rnd_sr());
        check_state("coincide a");
        pop_one();
        check_state("coincide b");
        pop_one();

        // Clear coinciding with a drop keeps overflow set
        for (int i = 0; i < 4; i++) tck_update(1'b0, 1'b1, '0, rnd_sr());
        udr_with_strobe(rnd_sr(), 1'b0);
        check_state("clr vs drop");

        // Randomized mix of updates, pops and clears
        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 5) tck_update($urandom_range(0, 2) == 0, 1'b1, 2'($urandom_range(0, 3)), rnd_sr());
            else if (op < 9) pop_one();
            else clr_ovf();
            check_state("random");
        end

        // Reset in the middle of traffic with three entries queued
        while (model_q.size() > 0) pop_one();
        for (int i = 0; i < 3; i++) tck_update(1'b0, 1'b1, '0, rnd_sr() | 38'h20_0000_0000);
        check_state("pre-reset");
        @(negedge clk);
        vs_udr = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async valid", 64'(cmd_valid), 64'd0);
        check_eq("async level", 64'(level), 64'd0);
        check_eq("async data", 64'(cmd_data), 64'd0);
        check_eq("async ir", 64'(cmd_ir), 64'd0);
        check_eq("async act", 64'(cmd_act), 64'd0);
        check_eq("async ovf", 64'(overflow), 64'd0);
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_q.delete();
        model_ir  = '0;
        model_ovf = 1'b0;
        repeat (20) @(negedge clk);
        check_state("post-reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
